digital_clock_set: RTL

- Parametrised, settable successor of the fixed 25 MHz digital clock.
- Owns its own seconds prescaler and BCD hh:mm:ss counters, with configurable input clock rate.
- Adds a user set-mode state machine driven by two button pulses, and a 12/24-hour display mode.
- Produces the same display buses as the existing clock: 7-seg nibble word plus two ASCII text words ("hh:m", "m:ss").

---
 rtl/digital_clock_pkg.sv | 10 +
 rtl/bcd_counter_2d.sv | 32 +++
 rtl/digital_clock_set.sv | 80 ++++++++
 3 files changed

// File: rtl/digital_clock_pkg.sv
// digital_clock_pkg: shared state encoding, BCD digit type and ASCII helpers for digital_clock_set
package digital_clock_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_SET_HOUR = 2'b01, ST_SET_MIN = 2'b10} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  function automatic logic [7:0] asc(input bcd_t d);
    return ASC_ZERO + {4'h0, d};
  endfunction
endpackage

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD counter 00..MAX with clear and a carry on wrap
module bcd_counter_2d import digital_clock_pkg::*; #(
  parameter int MAX  = 59,
  parameter int INIT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);
  localparam bcd_t TOP_T = bcd_t'(MAX / 10);
  localparam bcd_t TOP_O = bcd_t'(MAX % 10);
  logic w_top, w_nine;
  assign w_top = tens == TOP_T && ones == TOP_O;
  assign w_nine = ones == 4'd9;
  assign carry = inc && w_top;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tens <= bcd_t'(INIT / 10);
      ones <= bcd_t'(INIT % 10);
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      ones <= (w_top || w_nine) ? 4'd0 : ones + 4'd1;
      tens <= w_top ? 4'd0 : w_nine ? tens + 4'd1 : tens;
    end
  end
endmodule

// File: rtl/digital_clock_set.sv
// digital_clock_set: settable BCD hh:mm:ss clock with 12/24h display; DIGITAL_CLOCK_ALARM_EN adds an alarm
module digital_clock_set import digital_clock_pkg::*; #(
  parameter int         CLK_HZ     = 25_000_000,
  parameter logic [3:0] DASH_CODE  = 4'hA,
  parameter int         RESET_HOUR = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        hour12,
  output logic        sec_tick,
  output logic [1:0]  set_state,
  output logic        pm,
  output logic [31:0] segdata,
  output logic [31:0] textdata_e,
  output logic [31:0] textdata_f
`ifdef DIGITAL_CLOCK_ALARM_EN
  ,
  input  logic        alarm_on,
  input  logic [7:0]  alarm_hour,
  input  logic [7:0]  alarm_min,
  output logic        alarm_hit
`endif
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  state_t r_state, w_next;
  logic [PW-1:0] r_presc;
  logic w_tick, w_s_carry, w_m_carry, w_unused_day_carry;
  bcd_t w_s10, w_s1, w_m10, w_m1, w_h10, w_h1, w_dh10, w_dh1;
  logic [4:0] w_hour, w_dhour;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
      r_presc <= '0;
    end else begin
      r_state <= w_next;
      r_presc <= (r_state != ST_RUN || mode_btn || w_tick) ? '0 : r_presc + 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    if (mode_btn)
      w_next = r_state == ST_RUN ? ST_SET_HOUR : r_state == ST_SET_HOUR ? ST_SET_MIN : ST_RUN;
  end
  assign w_tick = r_state == ST_RUN && r_presc == PW'(CLK_HZ - 1);
  assign sec_tick = w_tick;
  assign set_state = r_state;
  bcd_counter_2d #(.MAX(59), .INIT(0)) u_sec (
    .clk, .resetn, .inc(w_tick), .clr(r_state == ST_RUN && mode_btn),
    .tens(w_s10), .ones(w_s1), .carry(w_s_carry)
  );
  // Minute carry only propagates from counted seconds, never from a manual minute set
  bcd_counter_2d #(.MAX(59), .INIT(0)) u_min (
    .clk, .resetn, .inc(w_s_carry || (r_state == ST_SET_MIN && inc_btn)), .clr(1'b0),
    .tens(w_m10), .ones(w_m1), .carry(w_m_carry)
  );
  bcd_counter_2d #(.MAX(23), .INIT(RESET_HOUR)) u_hour (
    .clk, .resetn, .inc((w_tick && w_m_carry) || (r_state == ST_SET_HOUR && inc_btn)), .clr(1'b0),
    .tens(w_h10), .ones(w_h1), .carry(w_unused_day_carry)
  );
  assign w_hour = 5'(w_h10) * 5'd10 + 5'(w_h1);
  assign pm = w_hour >= 5'd12;
  assign w_dhour = !hour12 ? w_hour : w_hour == 5'd0 ? 5'd12 : w_hour > 5'd12 ? w_hour - 5'd12 : w_hour;
  assign w_dh10 = w_dhour >= 5'd20 ? 4'd2 : w_dhour >= 5'd10 ? 4'd1 : 4'd0;
  assign w_dh1 = 4'(w_dhour - 5'(w_dh10) * 5'd10);
  assign segdata = {w_dh10, w_dh1, DASH_CODE, w_m10, w_m1, DASH_CODE, w_s10, w_s1};
  assign textdata_e = {asc(w_dh10), asc(w_dh1), ASC_COLON, asc(w_m10)};
  assign textdata_f = {asc(w_m1), ASC_COLON, asc(w_s10), asc(w_s1)};
`ifdef DIGITAL_CLOCK_ALARM_EN
  // The cycle after a counted second, the registered time shows the new hh:mm:ss
  logic r_tick_d;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_tick_d <= 1'b0;
    else r_tick_d <= w_tick;
  end
  assign alarm_hit = r_tick_d && r_state == ST_RUN && alarm_on && {w_h10, w_h1} == alarm_hour
                     && {w_m10, w_m1} == alarm_min && {w_s10, w_s1} == 8'h00;
`endif
endmodule
